// File: rtl/huffman_pkg.sv
// Shared types and defaults for the Huffman bit packer and its downstream decoder.
package huffman_pkg;

  localparam int HUFF_W     = 8;
  localparam int HUFF_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } huff_state_t;

  typedef struct packed {
    logic [HUFF_W-1:0] sym;
    logic [HUFF_W-1:0] code;
    logic [HUFF_W-1:0] width;
    logic              valid;
  } huff_entry_t;

endpackage

// File: rtl/huffman_code_table.sv
// Symbol-to-code table: sequential fill through a write pointer, combinational
// lookup across all valid entries with the lowest index winning on duplicates.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int W     = HUFF_W,
  parameter int DEPTH = HUFF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_sym,
  input  logic [W-1:0] wr_code,
  input  logic [W-1:0] wr_width,
  input  logic [W-1:0] lk_sym,
  output logic         hit,
  output logic [W-1:0] hit_code,
  output logic [W-1:0] hit_width
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr;
  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     sym_q   [DEPTH];
  logic [W-1:0]     code_q  [DEPTH];
  logic [W-1:0]     width_q [DEPTH];
  logic             wr_ok;
  logic [W-1:0]     wr_mask;

  assign wr_ok   = wr_en && (wr_ptr != PW'(DEPTH)) && (wr_width != '0) && (wr_width <= W'(W));
  // Bits above the code width are cleared so the packer can OR codes in blindly.
  assign wr_mask = ~({W{1'b1}} << wr_width);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      valid_q <= '0;
    end else if (wr_ok) begin
      wr_ptr                   <= wr_ptr + PW'(1);
      valid_q[wr_ptr[IW-1:0]]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst && !clr) begin
      sym_q[wr_ptr[IW-1:0]]   <= wr_sym;
      code_q[wr_ptr[IW-1:0]]  <= wr_code & wr_mask;
      width_q[wr_ptr[IW-1:0]] <= wr_width;
    end
  end

  always_comb begin
    hit       = 1'b0;
    hit_code  = '0;
    hit_width = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (sym_q[i] == lk_sym)) begin
        hit       = 1'b1;
        hit_code  = code_q[i];
        hit_width = width_q[i];
      end
    end
  end

endmodule

// File: rtl/huffman_pack.sv
// Huffman bit packer: maps symbols to variable-width codes and emits packed bytes on request.
// Define HUFF_PACK_ERR_CNT_EN to enable the saturating table-miss counter on err_cnt.
//
// state    | meaning
// ST_CFG   | table fill; no symbols accepted, datapath empty
// ST_RUN   | accept symbols, pop full bytes on d_req
// ST_FLUSH | no new symbols; pop full bytes, then a zero-padded partial byte
module huffman_pack
  import huffman_pkg::*;
#(
  parameter int W     = HUFF_W,
  parameter int DEPTH = HUFF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_conf,
  input  logic [W-1:0] h_conf,
  input  logic [W-1:0] w_conf,
  input  logic         en_conf,
  input  logic         new_conf,
  input  logic         conf_done,
  input  logic [W-1:0] sym_in,
  input  logic         sym_en,
  output logic         sym_rdy,
  input  logic         flush,
  input  logic         d_req,
  output logic [W-1:0] d_out,
  output logic         en_out,
  output logic         miss,
  output logic [7:0]   err_cnt,
  output logic         flush_done
);

  localparam int AW = 2 * W;
  localparam int CW = $clog2(AW + 1);

  huff_state_t   state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, acc_base, app_bits;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base, sh_amt;
  logic          tbl_hit;
  logic [W-1:0]  tbl_code, tbl_width;
  logic          accept, append, pop;
  logic          flush_done_d;

  huffman_code_table #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .clr       (new_conf),
    .wr_en     (en_conf && (state_q == ST_CFG)),
    .wr_sym    (d_conf),
    .wr_code   (h_conf),
    .wr_width  (w_conf),
    .lk_sym    (sym_in),
    .hit       (tbl_hit),
    .hit_code  (tbl_code),
    .hit_width (tbl_width)
  );

  assign sym_rdy = (state_q == ST_RUN) && (cnt_q <= CW'(W));
  assign accept  = sym_en && sym_rdy;
  assign append  = accept && tbl_hit;

  always_comb begin
    pop = 1'b0;
    case (state_q)
      ST_RUN:   pop = d_req && (cnt_q >= CW'(W));
      ST_FLUSH: pop = d_req && (cnt_q != '0);
      default:  pop = 1'b0;
    endcase
  end

  // The append lands directly below whatever remains after this cycle's pop.
  always_comb begin
    acc_base = acc_q;
    cnt_base = cnt_q;
    if (pop) begin
      acc_base = acc_q << W;
      cnt_base = (cnt_q >= CW'(W)) ? (cnt_q - CW'(W)) : '0;
    end
    sh_amt   = CW'(AW) - cnt_base - CW'(tbl_width);
    app_bits = {{W{1'b0}}, tbl_code} << sh_amt;
    acc_d    = acc_base;
    cnt_d    = cnt_base;
    if (append) begin
      acc_d = acc_base | app_bits;
      cnt_d = cnt_base + CW'(tbl_width);
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_CFG: begin
        if (conf_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush) begin
          if ((cnt_q == '0) && !append) flush_done_d = 1'b1;
          else                          state_d      = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || new_conf) begin
      state_q    <= ST_CFG;
      acc_q      <= '0;
      cnt_q      <= '0;
      d_out      <= '0;
      en_out     <= 1'b0;
      miss       <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      en_out     <= pop;
      miss       <= accept && !tbl_hit;
      flush_done <= flush_done_d;
      if (pop) d_out <= acc_q[AW-1:W];
    end
  end

`ifdef HUFF_PACK_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (!new_conf && accept && !tbl_hit && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_huffman_pack.sv
// Directed self-checking bench for huffman_pack with hand-computed expected bytes.
module tb_huffman_pack;
  import huffman_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 16;

`ifdef HUFF_PACK_ERR_CNT_EN
  localparam logic [7:0] ERR_ONE = 8'd1;
  localparam logic [7:0] ERR_TWO = 8'd2;
`else
  localparam logic [7:0] ERR_ONE = 8'd0;
  localparam logic [7:0] ERR_TWO = 8'd0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d_conf, h_conf, w_conf;
  logic         en_conf, new_conf, conf_done;
  logic [W-1:0] sym_in;
  logic         sym_en, sym_rdy;
  logic         flush, d_req;
  logic [W-1:0] d_out;
  logic         en_out, miss, flush_done;
  logic [7:0]   err_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] outq[$];
  int fd_cnt = 0;
  int fd_at  = -1;

  huffman_pack #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_conf     (d_conf),
    .h_conf     (h_conf),
    .w_conf     (w_conf),
    .en_conf    (en_conf),
    .new_conf   (new_conf),
    .conf_done  (conf_done),
    .sym_in     (sym_in),
    .sym_en     (sym_en),
    .sym_rdy    (sym_rdy),
    .flush      (flush),
    .d_req      (d_req),
    .d_out      (d_out),
    .en_out     (en_out),
    .miss       (miss),
    .err_cnt    (err_cnt),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (en_out) outq.push_back(d_out);
    if (flush_done) begin
      fd_cnt++;
      fd_at = outq.size();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [7:0] s, input logic [7:0] c, input logic [7:0] w);
    en_conf = 1'b1;
    d_conf  = s;
    h_conf  = c;
    w_conf  = w;
    @(negedge clk);
    en_conf = 1'b0;
  endtask

  task automatic pulse_new_conf();
    new_conf = 1'b1;
    @(negedge clk);
    new_conf = 1'b0;
  endtask

  task automatic pulse_conf_done();
    conf_done = 1'b1;
    @(negedge clk);
    conf_done = 1'b0;
  endtask

  task automatic send(input logic [7:0] s);
    sym_en = 1'b1;
    sym_in = s;
    @(negedge clk);
    sym_en = 1'b0;
  endtask

  initial begin
    int base;
    int fdb;
    rst = 1'b1; d_conf = '0; h_conf = '0; w_conf = '0;
    en_conf = 1'b0; new_conf = 1'b0; conf_done = 1'b0;
    sym_in = '0; sym_en = 1'b0; flush = 1'b0; d_req = 1'b0;
    idle(2);
    check("rst_d_out", d_out, 0);
    check("rst_en_out", en_out, 0);
    check("rst_sym_rdy", sym_rdy, 0);
    check("rst_miss", miss, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_state", dut.state_q, ST_CFG);
    rst = 1'b0;

    // two-bit codes packed into one byte: 00 01 00 01
    cfg_write(8'h20, 8'h00, 8'd2);
    cfg_write(8'h21, 8'h01, 8'd2);
    pulse_conf_done();
    check("a_rdy", sym_rdy, 1);
    base = outq.size();
    d_req = 1'b1;
    send(8'h20); send(8'h21); send(8'h20); send(8'h21);
    idle(4);
    d_req = 1'b0;
    check("a_nbytes", outq.size() - base, 1);
    check("a_byte", outq[base], 8'h11);
    check("a_hold", d_out, 8'h11);

    // 9 bits then flush: 0x96, padded 0x00, then flush_done
    pulse_new_conf();
    check("b_cfg_rdy", sym_rdy, 0);
    cfg_write(8'h30, 8'h04, 8'd3);
    cfg_write(8'h31, 8'h05, 8'd3);
    pulse_conf_done();
    base = outq.size();
    fdb  = fd_cnt;
    send(8'h30); send(8'h31); send(8'h30);
    check("b_rdy_full", sym_rdy, 0);
    check("b_no_early", outq.size() - base, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("b_state_flush", dut.state_q, ST_FLUSH);
    d_req = 1'b1;
    idle(5);
    d_req = 1'b0;
    check("b_nbytes", outq.size() - base, 2);
    check("b_byte0", outq[base], 8'h96);
    check("b_byte1", outq[base+1], 8'h00);
    check("b_fd_cnt", fd_cnt - fdb, 1);
    check("b_fd_after", fd_at, base + 2);
    check("b_state_run", dut.state_q, ST_RUN);

    // full-width codes with pop and append in the same cycle
    pulse_new_conf();
    cfg_write(8'h80, 8'hFC, 8'd8);
    cfg_write(8'h81, 8'hFD, 8'd8);
    pulse_conf_done();
    d_req = 1'b1;
    check("c_rdy0", sym_rdy, 1);
    sym_en = 1'b1; sym_in = 8'h80;
    @(negedge clk);
    check("c_rdy1", sym_rdy, 1);
    sym_in = 8'h81;
    @(negedge clk);
    check("c_rdy2", sym_rdy, 1);
    check("c_en0", en_out, 1);
    check("c_byte0", d_out, 8'hFC);
    sym_en = 1'b0;
    @(negedge clk);
    check("c_rdy3", sym_rdy, 1);
    check("c_en1", en_out, 1);
    check("c_byte1", d_out, 8'hFD);
    d_req = 1'b0;
    @(negedge clk);
    check("c_en_low", en_out, 0);
    check("c_hold", d_out, 8'hFD);

    // table miss
    base = outq.size();
    send(8'h55);
    check("d_miss", miss, 1);
    check("d_err_cnt", err_cnt, ERR_ONE);
    @(negedge clk);
    check("d_miss_clr", miss, 0);
    check("d_no_byte", outq.size() - base, 0);

    // pop + w2 append leaves 2 bits; three more w2 codes give 01010101
    pulse_new_conf();
    check("e_err_kept", err_cnt, ERR_ONE);
    cfg_write(8'h80, 8'hFC, 8'd8);
    cfg_write(8'h21, 8'h01, 8'd2);
    pulse_conf_done();
    send(8'h80);
    d_req = 1'b1;
    send(8'h21);
    d_req = 1'b0;
    check("e_en", en_out, 1);
    check("e_byte0", d_out, 8'hFC);
    check("e_rdy_cnt2", sym_rdy, 1);
    send(8'h21); send(8'h21); send(8'h21);
    d_req = 1'b1;
    @(negedge clk);
    d_req = 1'b0;
    check("e_en1", en_out, 1);
    check("e_byte1", d_out, 8'h55);
    send(8'h21);
    d_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("e_rst_d_out", d_out, 0);
    check("e_rst_en_out", en_out, 0);
    check("e_rst_rdy", sym_rdy, 0);
    check("e_rst_miss", miss, 0);
    check("e_rst_fd", flush_done, 0);
    check("e_rst_err", err_cnt, 0);
    check("e_rst_state", dut.state_q, ST_CFG);
    rst = 1'b0;
    base = outq.size();
    idle(3);
    d_req = 1'b0;
    check("e_discard", outq.size() - base, 0);

    // zero-width write ignored, 17th write ignored
    cfg_write(8'h40, 8'h03, 8'd0);
    for (int i = 0; i < DEPTH; i++) cfg_write(8'(i), 8'(i), 8'd4);
    cfg_write(8'h10, 8'h0A, 8'd4);
    pulse_conf_done();
    send(8'h40);
    check("f_w0_miss", miss, 1);
    send(8'h0F);
    check("f_last_hit", miss, 0);
    send(8'h10);
    check("f_over_miss", miss, 1);
    send(8'h00);
    check("f_first_hit", miss, 0);
    check("f_err_cnt", err_cnt, ERR_TWO);
    d_req = 1'b1;
    @(negedge clk);
    d_req = 1'b0;
    check("f_en", en_out, 1);
    check("f_byte", d_out, 8'hF0);

    // flush with empty buffer, then flush in CFG
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("g_fd_now", flush_done, 1);
    check("g_state", dut.state_q, ST_RUN);
    @(negedge clk);
    check("g_fd_once", flush_done, 0);
    pulse_new_conf();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("g_cfg_flush_state", dut.state_q, ST_CFG);
    @(negedge clk);
    check("g_cfg_flush_fd", flush_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/huffman_pack.md
HUFFMAN_PACK -- requirements
Module: huffman_pack

Interface
REQ-001 SHALL have parameter W, default 8, meaning symbol, code and output byte width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning code table entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports d_conf/h_conf/w_conf, input, W each: symbol, right-aligned code, code width.
REQ-006 SHALL have ports en_conf (write table entry) and new_conf (clear table and datapath), input, 1 each.
REQ-007 SHALL have port conf_done, input, 1, meaning leave configuration and enter RUN.
REQ-008 SHALL have ports sym_in (input, W), sym_en (input, 1) and sym_rdy (output, 1): symbol handshake.
REQ-009 SHALL have port flush, input, 1, meaning pad and drain the partial byte.
REQ-010 SHALL have port d_req, input, 1, meaning downstream decoder requests one byte.
REQ-011 SHALL have ports d_out (output, W) and en_out (output, 1): packed byte and its valid strobe.
REQ-012 SHALL have ports miss (output, 1), err_cnt (output, 8) and flush_done (output, 1).

Function
REQ-013 SHALL use states CFG, RUN, FLUSH; CFG->RUN on conf_done; RUN->FLUSH on flush; FLUSH->RUN after drain; any state->CFG on new_conf.
REQ-014 SHALL, in CFG with en_conf, write {d_conf, h_conf, w_conf} at write pointer and increment it; ignore writes when pointer = DEPTH or w_conf is 0 or >W.
REQ-015 SHALL accept a symbol when sym_en && sym_rdy; sym_rdy = (state==RUN) && (count <= 2W-W).
REQ-016 SHALL look up the accepted symbol combinationally against all valid entries; on duplicates the lowest index wins.
REQ-017 SHALL append the hit code MSB-first into a 2W-bit left-aligned accumulator directly below the count held bits, in the accept cycle.
REQ-018 SHALL, on a table miss, append nothing and pulse miss for one cycle, registered one cycle after the accept.
REQ-019 SHALL, when d_req is sampled with count >= W, drive the top W accumulator bits on d_out with en_out=1 the next cycle, shift the accumulator left by W and subtract W from count.
REQ-020 SHALL, for a simultaneous pop and append in one cycle, compute count' = count - W + w and position the append relative to the shifted data.
REQ-021 SHALL hold en_out low when d_req is high with count < W; the request is not queued.
REQ-022 SHALL, in FLUSH, pop full bytes on d_req; if 0 < count < W, zero-pad to W and emit on the next d_req; when count = 0, pulse flush_done once and return to RUN.
REQ-023 SHALL treat flush outside RUN as ignored and flush with count = 0 as an immediate flush_done pulse.
REQ-024 SHALL hold d_out stable between en_out strobes.

Reset
REQ-025 SHALL, on rst, set state CFG, write pointer 0, all entries invalid, accumulator 0, count 0, d_out 0, en_out 0, sym_rdy 0, miss 0, flush_done 0 and err_cnt 0.
REQ-026 SHALL, on new_conf, apply the rst values except err_cnt, which is retained.
REQ-027 SHALL, on rst or new_conf in mid-packing, discard buffered bits without emitting them.

Configuration
REQ-028 SHALL, with HUFF_PACK_ERR_CNT_EN defined, increment err_cnt by one per miss, saturating at 255.
REQ-029 SHALL, without HUFF_PACK_ERR_CNT_EN, drive err_cnt constant 0; the miss pulse is unaffected.

Structure
REQ-030 SHALL place the state enum, the table-entry struct {sym, code, width, valid} and the constants W and DEPTH defaults in package huffman_pkg, shared with the downstream decoder.
REQ-031 SHALL implement the table and lookup as sub-module huffman_code_table; the bit packer and FSM stay in huffman_pack.

Verification
REQ-032 SHALL cover: table {0x20->00 w2, 0x21->01 w2}, symbols 20,21,20,21, d_req held -> one en_out with d_out 0x11.
REQ-033 SHALL cover: table {0x30->100, 0x31->101 w3}, symbols 30,31,30 then flush -> 0x96, then 0x00, then a flush_done pulse.
REQ-034 SHALL cover: 0x80->11111100 w8 and 0x81->11111101 w8, symbols 80,81 -> 0xFC then 0xFD; sym_rdy stays high throughout.
REQ-035 SHALL cover: symbol 0x55 absent from the table -> miss pulse, err_cnt 1 (0 without the macro), no byte emitted.
REQ-036 SHALL cover: count=8 with d_req and a w2 append in the same cycle -> byte emitted and count=2; then rst mid-stream -> all outputs 0 and state CFG.
REQ-037 SHALL cover: DEPTH+1 en_conf writes -> last write ignored; w_conf=0 entry ignored.
